// File: rtl/bus_pkg.sv
// Shared types and sizes for the 16-source wired-OR bus drive arbiter.
package bus_pkg;

    localparam int NSRC     = 16;
    localparam int W        = 32;
    localparam int MAX_HOLD = 8;

    typedef logic [NSRC-1:0]               src_mask_t;
    typedef logic [3:0]                    src_idx_t;
    typedef logic [$clog2(MAX_HOLD)-1:0]   hold_cnt_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_drive_arbiter_if.sv
// Request/data/grant bundle between the sources and the bus drive arbiter.
interface bus_drive_arbiter_if;
    import bus_pkg::*;

    src_mask_t           req;
    logic [NSRC*W-1:0]   src_data;
    src_mask_t           gnt;
    logic [NSRC*W-1:0]   drv;
    logic                bus_valid;
    src_idx_t            owner;

    modport master (
        input  req, src_data,
        output gnt, drv, bus_valid, owner
    );

    modport slave (
        output req, src_data,
        input  gnt, drv, bus_valid, owner
    );
endinterface

// File: rtl/bus_drive_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req_mask scanning upward from rr_ptr with wrap.
module rr_pick
    import bus_pkg::*;
(
    input  src_mask_t req_mask,
    input  src_idx_t  rr_ptr,
    output src_mask_t pick,
    output src_idx_t  pick_idx,
    output logic      pick_vld
);

    src_idx_t idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        idx      = '0;
        // 4-bit index arithmetic wraps modulo NSRC for free
        for (int k = 0; k < NSRC; k++) begin
            idx = rr_ptr + src_idx_t'(k);
            if (!pick_vld && req_mask[idx]) begin
                pick_vld      = 1'b1;
                pick_idx      = idx;
                pick[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_drive_arbiter.sv
// Round-robin, hold-until-release arbiter gating source words onto wired-OR bus lanes.
// Optional BUS_ARB_TIMEOUT_EN forces release after MAX_HOLD cycles when others wait.
module bus_drive_arbiter
    import bus_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    bus_drive_arbiter_if.master  bus
);

    arb_state_e state_q, state_d;
    src_mask_t  gnt_q, gnt_d;
    src_idx_t   owner_q, owner_d;
    src_idx_t   rr_ptr_q, rr_ptr_d;
    logic       bus_valid_q, bus_valid_d;

    src_mask_t  pick;
    src_idx_t   pick_idx;
    logic       pick_vld;
    src_idx_t   arb_ptr;
    logic       release_c;

    // In GRANT the pick only matters on release, where the scan starts after the owner
    assign arb_ptr = (state_q == ARB_GRANT) ? src_idx_t'(owner_q + 4'd1) : rr_ptr_q;

    rr_pick u_rr_pick (
        .req_mask (bus.req),
        .rr_ptr   (arb_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    hold_cnt_t hold_cnt_q, hold_cnt_d;
    logic      timeout_c;

    assign timeout_c = (hold_cnt_q == hold_cnt_t'(MAX_HOLD - 1)) && |(bus.req & ~gnt_q);
`else
    logic      timeout_c;

    assign timeout_c = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        release_c = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick;
                    owner_d = pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ARB_GRANT: begin
                release_c = !bus.req[owner_q] || timeout_c;
                if (release_c) begin
                    rr_ptr_d = src_idx_t'(owner_q + 4'd1);
                    if (pick_vld) begin
                        gnt_d   = pick;
                        owner_d = pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt_d = '0;
`endif
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                    end
                end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                    if (hold_cnt_q != hold_cnt_t'(MAX_HOLD - 1))
                        hold_cnt_d = hold_cnt_q + hold_cnt_t'(1);
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                owner_d = '0;
            end
        endcase
        bus_valid_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            bus_valid_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            bus_valid_q <= bus_valid_d;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    logic [NSRC*W-1:0] drv_c;

    for (genvar i = 0; i < NSRC; i++) begin : g_lane
        assign drv_c[i*W +: W] = gnt_q[i] ? bus.src_data[i*W +: W] : '0;
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.drv       = drv_c;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Directed bench for bus_drive_arbiter: reset, round-robin, wrap, gating, reset mid-grant, timeout.
module tb_bus_drive_arbiter;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bus_drive_arbiter_if bif ();

    bus_drive_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [15:0] g, input logic [3:0] o);
        check({tag, ".gnt"}, 64'(bif.gnt), 64'(g));
        check({tag, ".owner"}, 64'(bif.owner), 64'(o));
        check({tag, ".valid"}, 64'(bif.bus_valid), 64'(g != 16'h0));
    endtask

    logic [15:0] t_exp [4];

    initial begin
        reset        = 1'b1;
        bif.req      = 16'hFFFF;
        bif.src_data = '1;
        step(2);
        check_grant("rst", 16'h0000, 4'd0);
        check("rst.drv", 64'(|bif.drv), 64'd0);
        reset = 1'b0;
        step(1);
        check_grant("first", 16'h0001, 4'd0);

        // round-robin 0,2,7,0 with single-cycle drops
        reset   = 1'b1;
        bif.req = 16'h0000;
        step(1);
        reset   = 1'b0;
        bif.req = 16'h0085;
        step(1);
        check_grant("rr0", 16'h0001, 4'd0);
        step(2);
        bif.req = 16'h0084;
        step(1);
        check_grant("rr2", 16'h0004, 4'd2);
        bif.req = 16'h0085;
        step(2);
        check_grant("rr2hold", 16'h0004, 4'd2);
        bif.req = 16'h0081;
        step(1);
        check_grant("rr7", 16'h0080, 4'd7);
        bif.req = 16'h0085;
        step(2);
        bif.req = 16'h0005;
        step(1);
        check_grant("rr0b", 16'h0001, 4'd0);
        bif.req = 16'h0000;
        step(1);
        check_grant("rridle", 16'h0000, 4'd0);

        // wrap: grant 14, release -> rr_ptr=15
        bif.req = 16'h4000;
        step(1);
        check_grant("w14", 16'h4000, 4'd14);
        bif.req = 16'h0000;
        step(1);
        bif.req = 16'h8001;
        step(1);
        check_grant("w15", 16'h8000, 4'd15);
        bif.req = 16'h0001;
        step(1);
        check_grant("w0", 16'h0001, 4'd0);

        // lane gating with owner 5
        for (int i = 0; i < NSRC; i++) bif.src_data[i*W +: W] = 32'hFFFFFFFF;
        bif.src_data[5*W +: W] = 32'hDEADBEEF;
        bif.req = 16'h0020;
        step(1);
        check_grant("g5", 16'h0020, 4'd5);
        for (int i = 0; i < NSRC; i++)
            check($sformatf("lane%0d", i), 64'(bif.drv[i*W +: W]),
                  (i == 5) ? 64'h00000000DEADBEEF : 64'h0);
        bif.src_data[5*W +: W] = 32'h12345678;
        #1;
        check("lane5.comb", 64'(bif.drv[5*W +: W]), 64'h0000000012345678);

        // reset mid-grant with owner 3
        bif.req = 16'h0008;
        step(1);
        check_grant("m3", 16'h0008, 4'd3);
        reset = 1'b1;
        step(1);
        check_grant("mrst", 16'h0000, 4'd0);
        check("mrst.drv", 64'(|bif.drv), 64'd0);
        reset = 1'b0;
        step(1);
        check_grant("m3b", 16'h0008, 4'd3);

        // timeout behaviour on two constant requesters
`ifdef BUS_ARB_TIMEOUT_EN
        t_exp = '{16'h0001, 16'h0002, 16'h0002, 16'h0001};
`else
        t_exp = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
`endif
        reset   = 1'b1;
        bif.req = 16'h0000;
        step(1);
        reset   = 1'b0;
        bif.req = 16'h0003;
        step(1);
        check("to.start", 64'(bif.gnt), 64'h1);
        step(7);
        check("to.c8", 64'(bif.gnt), 64'(t_exp[0]));
        step(1);
        check("to.c9", 64'(bif.gnt), 64'(t_exp[1]));
        step(7);
        check("to.c16", 64'(bif.gnt), 64'(t_exp[2]));
        step(1);
        check("to.c17", 64'(bif.gnt), 64'(t_exp[3]));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
